// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: state encodings and default width.
package serial_adder_ctrl_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/fullAdder.sv
// Single-bit full adder cell shared by the serial adder controller.
module fullAdder (
  input  logic Cin,
  input  logic A,
  input  logic B,
  output logic Cout,
  output logic S
);

  assign S    = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: walks one full-adder cell across WIDTH bits, LSB first,
// with a start/done handshake toward the requester.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] sa_reg, sb_reg;
  logic [WIDTH-2:0] partial_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             carry_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;
  logic             accept;
  logic             fa_cout, fa_s;

  fullAdder u_fa (
    .Cin  (carry_reg),
    .A    (sa_reg[0]),
    .B    (sb_reg[0]),
    .Cout (fa_cout),
    .S    (fa_s)
  );

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_reg == LAST) state_next = DONE;
      end
      DONE: begin
        // A start held through the DONE cycle chains straight into the next add.
        if (start) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      sa_reg      <= '0;
      sb_reg      <= '0;
      partial_reg <= '0;
      cnt_reg     <= '0;
      carry_reg   <= 1'b0;
      sum_reg     <= '0;
      cout_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        sa_reg      <= a;
        sb_reg      <= b;
        carry_reg   <= cin;
        cnt_reg     <= '0;
        partial_reg <= '0;
      end else if (state_reg == SHIFT) begin
        sa_reg      <= sa_reg >> 1;
        sb_reg      <= sb_reg >> 1;
        carry_reg   <= fa_cout;
        cnt_reg     <= cnt_reg + CNT_W'(1);
        // New sum bit enters at the top; after WIDTH-1 steps bit 0 sits at the LSB.
        partial_reg <= (WIDTH-1)'({fa_s, partial_reg} >> 1);
        if (cnt_reg == LAST) begin
          sum_reg  <= {fa_s, partial_reg};
          cout_reg <= fa_cout;
        end
      end
    end
  end

  assign busy = (state_reg == SHIFT);
  assign done = (state_reg == DONE);
  assign sum  = sum_reg;
  assign cout = cout_reg;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench: stimulus pushes expected {cout,sum}; a monitor pops on each done pulse.
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       cin8 = 1'b0;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;

  logic       start2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0;
  logic       cin2 = 1'b0;
  logic       busy2, done2, cout2;
  logic [1:0] sum2;

  int tests = 0;
  int fails = 0;
  int done_cnt8 = 0;

  logic [8:0] exp8[$];
  logic [2:0] exp2[$];

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder_ctrl #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end else begin
      $display("[TB] ok %s: %0h", name, act);
    end
  endtask

  // Monitor: one scoreboard pop per done pulse.
  always @(negedge clk) begin
    if (done8) begin
      done_cnt8++;
      tests++;
      if (exp8.size() == 0) begin
        fails++;
        $display("FAIL w8_unexpected_done: got result %0h, expected none", {cout8, sum8});
      end else begin
        logic [8:0] e;
        e = exp8.pop_front();
        if ({cout8, sum8} !== e || busy8 !== 1'b0) begin
          fails++;
          $display("FAIL w8_result: got {cout,sum}=%0h busy=%0b, expected %0h busy=0",
                   {cout8, sum8}, busy8, e);
        end else begin
          $display("[TB] w8 done {cout,sum}=%0h", {cout8, sum8});
        end
      end
    end
    if (done2) begin
      tests++;
      if (exp2.size() == 0) begin
        fails++;
        $display("FAIL w2_unexpected_done: got result %0h, expected none", {cout2, sum2});
      end else begin
        logic [2:0] e;
        e = exp2.pop_front();
        if ({cout2, sum2} !== e || busy2 !== 1'b0) begin
          fails++;
          $display("FAIL w2_result: got {cout,sum}=%0h busy=%0b, expected %0h busy=0",
                   {cout2, sum2}, busy2, e);
        end else begin
          $display("[TB] w2 done {cout,sum}=%0h", {cout2, sum2});
        end
      end
    end
  end

  // Called at a negedge: present operands with start high.
  task automatic issue8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                        input logic [8:0] expected, input bit push);
    a8 = ta; b8 = tb; cin8 = tc; start8 = 1'b1;
    if (push) exp8.push_back(expected);
  endtask

  // Follows an accepted operation to its done cycle; optionally chains the next op.
  task automatic track8(input string name, input bit mid_start, input bit chain,
                        input logic [7:0] na, input logic [7:0] nb, input logic nc,
                        input logic [8:0] nexp);
    logic [8:0] prev;
    int lat, busy_cnt;
    bit held_ok;
    prev = {cout8, sum8};
    lat = 0; busy_cnt = 0; held_ok = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) start8 = 1'b0;
      if (mid_start && i == 3) begin a8 = 8'h11; start8 = 1'b1; end
      if (mid_start && i == 4) start8 = 1'b0;
      if (busy8) begin
        busy_cnt++;
        if ({cout8, sum8} !== prev) held_ok = 1'b0;
      end
      if (done8) begin
        lat = i;
        if (chain) issue8(na, nb, nc, nexp, 1'b1);
        break;
      end
    end
    check({name, "_latency_edges"}, lat - 1, 8);
    check({name, "_busy_cycles"}, busy_cnt, 8);
    check({name, "_held_while_busy"}, {31'b0, held_ok}, 1);
  endtask

  initial begin
    int d0;
    // Reset state
    #2;
    check("reset_busy", {31'b0, busy8}, 0);
    check("reset_done", {31'b0, done8}, 0);
    check("reset_sum_cout", {23'b0, cout8, sum8}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue8(8'h3C, 8'h0F, 1'b0, 9'h04B, 1'b1);
    track8("add_3c_0f", 1'b0, 1'b0, '0, '0, 1'b0, '0);
    repeat (2) @(negedge clk);

    issue8(8'hFF, 8'h01, 1'b0, 9'h100, 1'b1);
    track8("add_ff_01", 1'b0, 1'b0, '0, '0, 1'b0, '0);
    @(negedge clk);
    issue8(8'h00, 8'h00, 1'b1, 9'h001, 1'b1);
    track8("add_cin_only", 1'b0, 1'b0, '0, '0, 1'b0, '0);
    repeat (2) @(negedge clk);

    // start during SHIFT must be ignored
    d0 = done_cnt8;
    issue8(8'hAA, 8'h55, 1'b0, 9'h0FF, 1'b1);
    track8("mid_start", 1'b1, 1'b0, '0, '0, 1'b0, '0);
    repeat (12) @(negedge clk);
    check("mid_start_done_pulses", done_cnt8 - d0, 1);

    // Back-to-back: start held in the DONE cycle
    issue8(8'h01, 8'h02, 1'b0, 9'h003, 1'b1);
    track8("b2b_first", 1'b0, 1'b1, 8'h80, 8'h80, 1'b0, 9'h100);
    track8("b2b_second", 1'b0, 1'b0, '0, '0, 1'b0, '0);
    repeat (2) @(negedge clk);

    // Asynchronous reset in the middle of an add
    issue8(8'h12, 8'h34, 1'b0, 9'h046, 1'b0);
    @(negedge clk); start8 = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_abort_busy", {31'b0, busy8}, 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", {31'b0, busy8}, 0);
    check("abort_done", {31'b0, done8}, 0);
    check("abort_sum_cout", {23'b0, cout8, sum8}, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("abort_no_done", {31'b0, done8}, 0);
    issue8(8'h12, 8'h34, 1'b0, 9'h046, 1'b1);
    track8("after_abort", 1'b0, 1'b0, '0, '0, 1'b0, '0);
    repeat (2) @(negedge clk);

    // Exhaustive at WIDTH=2
    for (int v = 0; v < 32; v++) begin
      logic [4:0] vv;
      bit seen;
      vv = 5'(v);
      @(negedge clk);
      cin2 = vv[4]; a2 = vv[3:2]; b2 = vv[1:0]; start2 = 1'b1;
      exp2.push_back({1'b0, vv[3:2]} + {1'b0, vv[1:0]} + {2'b0, vv[4]});
      @(negedge clk); start2 = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
        if (done2) begin seen = 1'b1; break; end
        @(negedge clk);
      end
      if (!seen) check("w2_timeout", 0, 1);
    end
    repeat (3) @(negedge clk);

    check("w8_queue_drained", exp8.size(), 0);
    check("w2_queue_drained", exp2.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
